// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction cache.
//   icache_state_t : controller states (IDLE, FETCH, FILL)
//   TAG_W/INDEX_W/OFFSET_W : address split for the default 8 x 16-byte cache
//   BLOCK_W / WORD_W       : refill block and instruction word widths
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FILL  = 2'd2
   } icache_state_t;

   localparam int NUM_BLOCKS_DFLT = 8;
   localparam int WORDS_DFLT      = 4;
   localparam int ADDR_W_DFLT     = 10;

   localparam int WORD_W   = 32;
   localparam int BLOCK_W  = 128;
   localparam int OFFSET_W = $clog2(WORDS_DFLT * 4);
   localparam int INDEX_W  = $clog2(NUM_BLOCKS_DFLT);
   localparam int TAG_W    = ADDR_W_DFLT - INDEX_W - OFFSET_W;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
//   CLK, RESET            : clock, async active-low reset (clears valid bits only)
//   rd_index/rd_tag/rd_word: combinational lookup from the current PC
//   hit, rd_data          : lookup result and selected 32-bit word
//   fill_en/fill_index/fill_tag/fill_data : synchronous whole-block refill
module icache_line_store
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = NUM_BLOCKS_DFLT,
   parameter int TAG_BITS   = TAG_W,
   parameter int IDX_BITS   = INDEX_W,
   parameter int SEL_BITS   = OFFSET_W - 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [IDX_BITS-1:0] rd_index,
   input  logic [TAG_BITS-1:0] rd_tag,
   input  logic [SEL_BITS-1:0] rd_word,
   output logic                hit,
   output logic [WORD_W-1:0]   rd_data,
   input  logic                fill_en,
   input  logic [IDX_BITS-1:0] fill_index,
   input  logic [TAG_BITS-1:0] fill_tag,
   input  logic [BLOCK_W-1:0]  fill_data
);

   logic [NUM_BLOCKS-1:0] valid_q;
   logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

   // Only the valid bits see reset; stale tags/data are harmless once invalid.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         valid_q <= '0;
      else if (fill_en)
         valid_q[fill_index] <= 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (fill_en) begin
         tag_q[fill_index]  <= fill_tag;
         data_q[fill_index] <= fill_data;
      end
   end

   assign hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
   assign rd_data = data_q[rd_index][WORD_W*rd_word +: WORD_W];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache.
//   CLK, RESET     : clock, async active-low reset
//   PC             : word-aligned fetch address (bits above ADDR_W ignored)
//   INSTRUCTION    : fetched word, valid while BUSYWAIT = 0 (else 0)
//   BUSYWAIT       : CPU stall, combinational on a miss
//   MEM_READ       : registered block-read request, high for the FETCH cycles
//   MEM_ADDRESS    : latched {tag, index} of the block being fetched
//   MEM_READDATA   : 128-bit block from memory
//   MEM_BUSYWAIT   : memory still busy with the read
module instruction_cache
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS      = NUM_BLOCKS_DFLT,
   parameter int WORDS_PER_BLOCK = WORDS_DFLT,
   parameter int ADDR_W          = ADDR_W_DFLT
) (
   input  logic                                        CLK,
   input  logic                                        RESET,
   input  logic [31:0]                                 PC,
   output logic [31:0]                                 INSTRUCTION,
   output logic                                        BUSYWAIT,
   output logic                                        MEM_READ,
   output logic [ADDR_W-$clog2(WORDS_PER_BLOCK)-3:0]   MEM_ADDRESS,
   input  logic [BLOCK_W-1:0]                          MEM_READDATA,
   input  logic                                        MEM_BUSYWAIT
);

   localparam int SEL_W = $clog2(WORDS_PER_BLOCK);
   localparam int OFF_W = SEL_W + 2;
   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int TG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int BA_W  = TG_W + IDX_W;

   logic [TG_W-1:0]   pc_tag;
   logic [IDX_W-1:0]  pc_index;
   logic [SEL_W-1:0]  pc_word;
   logic              unused_pc_bits;

   assign pc_tag         = PC[ADDR_W-1 -: TG_W];
   assign pc_index       = PC[OFF_W +: IDX_W];
   assign pc_word        = PC[2 +: SEL_W];
   assign unused_pc_bits = ^{PC[31:ADDR_W], PC[1:0]};

   icache_state_t     state_q, state_d;
   logic              mem_read_q;
   logic [BA_W-1:0]   mem_addr_q;
   logic              hit;
   logic [WORD_W-1:0] word;
   logic              fill_en;

   // The block lands on the first FETCH edge where memory is no longer busy.
   // Index/tag come from the latched address, so a PC that wanders while
   // stalled cannot redirect the fill.
   assign fill_en = (state_q == FETCH) && !MEM_BUSYWAIT;

   icache_line_store #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .TAG_BITS   (TG_W),
      .IDX_BITS   (IDX_W),
      .SEL_BITS   (SEL_W)
   ) u_store (
      .CLK        (CLK),
      .RESET      (RESET),
      .rd_index   (pc_index),
      .rd_tag     (pc_tag),
      .rd_word    (pc_word),
      .hit        (hit),
      .rd_data    (word),
      .fill_en    (fill_en),
      .fill_index (mem_addr_q[IDX_W-1:0]),
      .fill_tag   (mem_addr_q[BA_W-1 -: TG_W]),
      .fill_data  (MEM_READDATA)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!hit)          state_d = FETCH;
         FETCH:   if (!MEM_BUSYWAIT) state_d = FILL;
         FILL:                       state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         mem_read_q <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_read_q <= (state_d == FETCH);
         if (state_q == IDLE && !hit)
            mem_addr_q <= {pc_tag, pc_index};
      end
   end

   // In reset the valid bits are clear, so !hit alone would stall; the
   // explicit RESET term keeps BUSYWAIT low while reset is held.
   assign BUSYWAIT    = RESET && ((state_q != IDLE) || !hit);
   assign INSTRUCTION = (state_q == IDLE && hit) ? word : '0;
   assign MEM_READ    = mem_read_q;
   assign MEM_ADDRESS = mem_addr_q;

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic [31:0]  PC = '0;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   int tests = 0;
   int fails = 0;
   int lat   = 1;   // number of FETCH cycles the memory model takes
   int mem_cnt;

   typedef struct {
      logic [31:0] pc;
      int          lat;
      bit          miss;
      logic [5:0]  maddr;
      logic [31:0] instr;
      string       name;
   } vec_t;

   vec_t        vecs [11];
   logic [31:0] exp_q [$];

   always #5 CLK = ~CLK;

   instruction_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   // Memory contents: block 0 and the top word of block 3F are fixed by the
   // test plan; every other word is C000_0000 | addr<<8 | word.
   function automatic logic [31:0] mem_word(input logic [5:0] a, input int w);
      logic [1:0] ws;
      ws = w[1:0];
      if (a == 6'h00) begin
         case (ws)
            2'd0:    return 32'h08040000;
            2'd1:    return 32'h00000001;
            2'd2:    return 32'h00000002;
            default: return 32'h00000003;
         endcase
      end
      if (a == 6'h3F && ws == 2'd3) return 32'hDEADBEEF;
      return 32'hC000_0000 | {18'h0, a, 6'h0, ws};
   endfunction

   function automatic logic [127:0] mem_block(input logic [5:0] a);
      logic [127:0] b;
      for (int w = 0; w < 4; w++) b[32*w +: 32] = mem_word(a, w);
      return b;
   endfunction

   assign MEM_READDATA = mem_block(MEM_ADDRESS);

   always @(posedge CLK or negedge RESET) begin
      if (!RESET)        mem_cnt <= 0;
      else if (MEM_READ) mem_cnt <= mem_cnt + 1;
      else               mem_cnt <= 0;
   end
   assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < lat - 1);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; drives PC, follows the access to completion and
   // returns at posedge+1 one idle-hit cycle later.
   task automatic run_vec(input vec_t v);
      int          nb, nr;
      logic [5:0]  seen;
      logic [31:0] e;
      PC  = v.pc;
      lat = v.lat;
      exp_q.push_back(v.instr);
      #1;
      chk({v.name, " busy_first"}, BUSYWAIT, v.miss);
      chk({v.name, " read_first"}, MEM_READ, 0);
      nb = 0; nr = 0; seen = v.maddr;
      while (BUSYWAIT === 1'b1 && nb < 200) begin
         nb++;
         if (MEM_READ === 1'b1) begin
            nr++;
            if (MEM_ADDRESS !== v.maddr) seen = MEM_ADDRESS;
         end
         @(posedge CLK); #1;
      end
      chk({v.name, " busy_cycles"}, nb, v.miss ? v.lat + 2 : 0);
      chk({v.name, " read_cycles"}, nr, v.miss ? v.lat : 0);
      if (v.miss) chk({v.name, " mem_addr"}, seen, v.maddr);
      e = exp_q.pop_front();
      chk({v.name, " instr"}, INSTRUCTION, e);
      chk({v.name, " read_after"}, MEM_READ, 0);
      @(posedge CLK); #1;
   endtask

   initial begin
      int n;
      vecs[0]  = '{32'h000, 5,  1'b1, 6'h00, 32'h08040000, "cold"};
      vecs[1]  = '{32'h004, 1,  1'b0, 6'h00, 32'h00000001, "seq4"};
      vecs[2]  = '{32'h008, 1,  1'b0, 6'h00, 32'h00000002, "seq8"};
      vecs[3]  = '{32'h00C, 1,  1'b0, 6'h00, 32'h00000003, "seq12"};
      vecs[4]  = '{32'h080, 3,  1'b1, 6'h08, 32'hC0000800, "conflict_a"};
      vecs[5]  = '{32'h000, 2,  1'b1, 6'h00, 32'h08040000, "conflict_b"};
      vecs[6]  = '{32'h000, 1,  1'b0, 6'h00, 32'h08040000, "conflict_hit"};
      vecs[7]  = '{32'h3FC, 1,  1'b1, 6'h3F, 32'hDEADBEEF, "top"};
      vecs[8]  = '{32'h7FC, 1,  1'b0, 6'h3F, 32'hDEADBEEF, "top_alias"};
      vecs[9]  = '{32'h0F4, 4,  1'b1, 6'h0F, 32'hC0000F01, "evict_top"};
      vecs[10] = '{32'h110, 21, 1'b1, 6'h11, 32'hC0001100, "long_stall"};

      // Reset state
      #1 RESET = 1'b0;
      #1;
      chk("reset busywait", BUSYWAIT, 0);
      chk("reset mem_read", MEM_READ, 0);
      chk("reset mem_addr", MEM_ADDRESS, 0);
      chk("reset instr", INSTRUCTION, 0);
      repeat (2) @(posedge CLK);
      #1;
      chk("reset busywait held", BUSYWAIT, 0);
      RESET = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset during cycle 3 of FETCH
      PC  = 32'h040;
      lat = 10;
      n = 0;
      while (MEM_READ !== 1'b1 && n < 20) begin
         @(posedge CLK); #1; n++;
      end
      chk("midrst fetch started", MEM_READ, 1);
      chk("midrst mem_addr", MEM_ADDRESS, 6'h04);
      repeat (2) @(posedge CLK);
      #3 RESET = 1'b0;
      #1;
      chk("midrst mem_read", MEM_READ, 0);
      chk("midrst busywait", BUSYWAIT, 0);
      chk("midrst mem_addr clr", MEM_ADDRESS, 0);
      chk("midrst instr", INSTRUCTION, 0);
      @(posedge CLK); #1;
      RESET = 1'b1;
      run_vec('{32'h040, 2, 1'b1, 6'h04, 32'hC0000400, "midrst_refetch"});
      run_vec('{32'h000, 3, 1'b1, 6'h00, 32'h08040000, "midrst_cold"});
      run_vec('{32'h008, 1, 1'b0, 6'h00, 32'h00000002, "midrst_hit"});

      chk("scoreboard drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
